// File: rtl/pc_gen.sv
// Program-counter generator: start-up from IDLE, sequential/branch/flush PC
// selection, WFI sleep and debug halt, plus a fetch counter for status.
module pc_gen #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_pc,
  input  logic [31:0] start_addr,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [31:0] flush_target,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  input  logic        is_wfi,
  input  logic        wfi_wake,
  input  logic        halt_req,
  output logic [31:0] pc,
  output logic        ce,
  output logic        pc_invalid,
  output logic [1:0]  pc_state,
  output logic [31:0] fetch_cnt
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] WFI  = 2'b10;
  localparam logic [1:0] HALT = 2'b11;

  logic [31:0] pc_q, pc_d;
  logic        ce_q, ce_d;
  logic [1:0]  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;

  // NOTE: every next-state signal takes its hold value first, so no path
  // through the case below can leave one unassigned and infer a latch.
  always_comb begin
    pc_d    = pc_q;
    ce_d    = ce_q;
    state_d = state_q;

    case (state_q)
      IDLE: begin
        ce_d = 1'b0;
        if (start_pc) begin
          state_d = RUN;
          pc_d    = start_addr;
          ce_d    = 1'b1;
        end
      end

      RUN: begin
        ce_d = 1'b1;
        if (halt_req) begin
          state_d = HALT;
          ce_d    = 1'b0;
        end else if (flush) begin
          pc_d = flush_target;
        end else if (stall[0]) begin
          // ID re-presents branch/WFI once the stall lifts.
          pc_d = pc_q;
        end else if (is_wfi) begin
          state_d = WFI;
          ce_d    = 1'b0;
        end else if (branch_flag) begin
          pc_d = branch_target;
        end else begin
          pc_d = pc_q + 32'd4;
        end
      end

      WFI: begin
        ce_d = 1'b0;
        if (flush) begin
          state_d = RUN;
          pc_d    = flush_target;
          ce_d    = 1'b1;
        end else if (wfi_wake) begin
          state_d = RUN;
          ce_d    = 1'b1;
        end else if (halt_req) begin
          state_d = HALT;
        end
      end

      default: begin  // HALT
        ce_d = 1'b0;
        if (flush) pc_d = flush_target;
        if (!halt_req) begin
          state_d = RUN;
          ce_d    = 1'b1;
        end
      end
    endcase
  end

  // A fetch is issued in any cycle the enable is up and the PC stage is not stalled.
  always_comb begin
    cnt_d = cnt_q;
    if (ce_q && !stall[0]) cnt_d = cnt_q + 32'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q    <= RESET_PC;
      ce_q    <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= 32'd0;
    end else begin
      pc_q    <= pc_d;
      ce_q    <= ce_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc         = pc_q;
  assign ce         = ce_q;
  assign pc_state   = state_q;
  assign fetch_cnt  = cnt_q;
  assign pc_invalid = ce_q & (pc_q[1:0] != 2'b00);

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: a per-cycle vector table followed by a few
// hand-written multi-cycle sequences for WFI/HALT corner cases.
module tb_pc_gen;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_WFI  = 2'b10;
  localparam logic [1:0] S_HALT = 2'b11;

  logic        clk;
  logic        rst;
  logic        start_pc;
  logic [31:0] start_addr;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] flush_target;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        is_wfi;
  logic        wfi_wake;
  logic        halt_req;
  logic [31:0] pc;
  logic        ce;
  logic        pc_invalid;
  logic [1:0]  pc_state;
  logic [31:0] fetch_cnt;

  int errors = 0;
  int checks = 0;

  pc_gen #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_pc     (start_pc),
    .start_addr   (start_addr),
    .stall        (stall),
    .flush        (flush),
    .flush_target (flush_target),
    .branch_flag  (branch_flag),
    .branch_target(branch_target),
    .is_wfi       (is_wfi),
    .wfi_wake     (wfi_wake),
    .halt_req     (halt_req),
    .pc           (pc),
    .ce           (ce),
    .pc_invalid   (pc_invalid),
    .pc_state     (pc_state),
    .fetch_cnt    (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        start;
    logic [31:0] saddr;
    logic        stall0;
    logic        flush;
    logic [31:0] ftgt;
    logic        br;
    logic [31:0] btgt;
    logic        wfi;
    logic        wake;
    logic        halt;
    logic [31:0] exp_pc;
    logic        exp_ce;
    logic [1:0]  exp_st;
    logic [31:0] exp_cnt;
    logic        exp_inv;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic rst_v, input logic st, input logic [31:0] sa,
    input logic s0, input logic fl, input logic [31:0] ft,
    input logic br, input logic [31:0] bt,
    input logic wf, input logic wk, input logic hl,
    input logic [31:0] epc, input logic ece, input logic [1:0] est,
    input logic [31:0] ecnt, input logic einv);
    vec_t v;
    v.rst = rst_v; v.start = st; v.saddr = sa; v.stall0 = s0;
    v.flush = fl; v.ftgt = ft; v.br = br; v.btgt = bt;
    v.wfi = wf; v.wake = wk; v.halt = hl;
    v.exp_pc = epc; v.exp_ce = ece; v.exp_st = est;
    v.exp_cnt = ecnt; v.exp_inv = einv;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Upper stall bits are driven non-zero to show only bit 0 matters.
  task automatic drive(input logic rst_v, input logic st, input logic [31:0] sa,
                       input logic s0, input logic fl, input logic [31:0] ft,
                       input logic br, input logic [31:0] bt,
                       input logic wf, input logic wk, input logic hl);
    rst = rst_v; start_pc = st; start_addr = sa;
    stall = {5'b10110, s0};
    flush = fl; flush_target = ft;
    branch_flag = br; branch_target = bt;
    is_wfi = wf; wfi_wake = wk; halt_req = hl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_core(input string tag, input logic [31:0] epc,
                             input logic ece, input logic [1:0] est);
    check({tag, ".pc"},    pc,               epc);
    check({tag, ".ce"},    {31'd0, ce},       {31'd0, ece});
    check({tag, ".state"}, {30'd0, pc_state}, {30'd0, est});
  endtask

  initial begin
    drive(1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    //          rst st saddr          s0 fl ftgt           br btgt           wf wk hl  pc             ce st      cnt  inv
    vecs.push_back(mk(0, 0, 0,             0, 0, 0,             0, 0,             0, 0, 0, 32'h0,         0, S_IDLE, 0,  0));
    vecs.push_back(mk(1, 0, 32'h5555_0000, 0, 0, 0,             0, 0,             0, 0, 0, 32'h0,         0, S_IDLE, 0,  0));
    vecs.push_back(mk(1, 1, 32'h0000_1000, 0, 0, 0,             0, 0,             0, 0, 0, 32'h1000,      1, S_RUN,  0,  0));
    vecs.push_back(mk(1, 0, 0,             0, 0, 0,             0, 0,             0, 0, 0, 32'h1004,      1, S_RUN,  1,  0));
    vecs.push_back(mk(1, 0, 0,             0, 0, 0,             0, 0,             0, 0, 0, 32'h1008,      1, S_RUN,  2,  0));
    vecs.push_back(mk(1, 0, 0,             0, 0, 0,             0, 0,             0, 0, 0, 32'h100C,      1, S_RUN,  3,  0));
    vecs.push_back(mk(1, 0, 0,             0, 0, 0,             1, 32'h2000,      0, 0, 0, 32'h2000,      1, S_RUN,  4,  0));
    vecs.push_back(mk(1, 0, 0,             1, 0, 0,             1, 32'h3000,      0, 0, 0, 32'h2000,      1, S_RUN,  4,  0));
    vecs.push_back(mk(1, 0, 0,             1, 0, 0,             1, 32'h3000,      0, 0, 0, 32'h2000,      1, S_RUN,  4,  0));
    vecs.push_back(mk(1, 0, 0,             1, 0, 0,             1, 32'h3000,      0, 0, 0, 32'h2000,      1, S_RUN,  4,  0));
    vecs.push_back(mk(1, 0, 0,             0, 0, 0,             1, 32'h3000,      0, 0, 0, 32'h3000,      1, S_RUN,  5,  0));
    vecs.push_back(mk(1, 0, 0,             1, 1, 32'h8000,      1, 32'h3000,      0, 0, 0, 32'h8000,      1, S_RUN,  5,  0));
    vecs.push_back(mk(1, 0, 0,             0, 0, 0,             0, 0,             0, 0, 0, 32'h8004,      1, S_RUN,  6,  0));
    vecs.push_back(mk(1, 0, 0,             0, 0, 0,             1, 32'h0100,      0, 0, 0, 32'h0100,      1, S_RUN,  7,  0));
    vecs.push_back(mk(1, 0, 0,             0, 0, 0,             0, 0,             1, 0, 0, 32'h0100,      0, S_WFI,  8,  0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1, 0, 0,           0, 0, 0,             0, 0,             0, 0, 0, 32'h0100,      0, S_WFI,  8,  0));
    vecs.push_back(mk(1, 0, 0,             0, 0, 0,             0, 0,             0, 1, 0, 32'h0100,      1, S_RUN,  8,  0));
    vecs.push_back(mk(1, 0, 0,             0, 0, 0,             0, 0,             0, 0, 0, 32'h0104,      1, S_RUN,  9,  0));
    vecs.push_back(mk(1, 0, 0,             0, 0, 0,             1, 32'h0000_0006, 0, 0, 0, 32'h0006,      1, S_RUN,  10, 1));
    vecs.push_back(mk(1, 0, 0,             0, 0, 0,             0, 0,             0, 0, 0, 32'h000A,      1, S_RUN,  11, 1));
    vecs.push_back(mk(1, 0, 0,             0, 0, 0,             1, 32'hFFFF_FFFC, 0, 0, 0, 32'hFFFF_FFFC, 1, S_RUN,  12, 0));
    vecs.push_back(mk(1, 0, 0,             0, 0, 0,             0, 0,             0, 0, 0, 32'h0000_0000, 1, S_RUN,  13, 0));
    vecs.push_back(mk(1, 0, 0,             0, 0, 0,             0, 0,             0, 0, 1, 32'h0000_0000, 0, S_HALT, 14, 0));
    vecs.push_back(mk(1, 0, 0,             0, 1, 32'h0000_0042, 0, 0,             0, 0, 1, 32'h0000_0042, 0, S_HALT, 14, 0));
    vecs.push_back(mk(0, 0, 0,             0, 0, 0,             0, 0,             0, 0, 1, 32'h0000_0000, 0, S_IDLE, 0,  0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].start, vecs[i].saddr, vecs[i].stall0, vecs[i].flush,
            vecs[i].ftgt, vecs[i].br, vecs[i].btgt, vecs[i].wfi, vecs[i].wake, vecs[i].halt);
      tick();
      expect_core($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_ce, vecs[i].exp_st);
      check($sformatf("vec%0d.cnt", i), fetch_cnt, vecs[i].exp_cnt);
      check($sformatf("vec%0d.inv", i), {31'd0, pc_invalid}, {31'd0, vecs[i].exp_inv});
    end

    // WFI exits: stalled WFI ignored, flush beats wake, wake via halt path.
    drive(1, 1, 32'h200, 0, 0, 0, 0, 0, 0, 0, 0); tick(); expect_core("seq.start", 32'h200, 1, S_RUN);
    drive(1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0);       tick(); expect_core("seq.stallwfi", 32'h200, 1, S_RUN);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);       tick(); expect_core("seq.wfi", 32'h200, 0, S_WFI);
    drive(1, 0, 0, 0, 1, 32'h300, 0, 0, 0, 1, 0); tick(); expect_core("seq.flushwake", 32'h300, 1, S_RUN);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);       tick(); expect_core("seq.wfi2", 32'h300, 0, S_WFI);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);       tick(); expect_core("seq.wfihalt", 32'h300, 0, S_HALT);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);       tick(); expect_core("seq.resume", 32'h300, 1, S_RUN);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);       tick(); expect_core("seq.adv", 32'h304, 1, S_RUN);
    // Halt outranks a simultaneous flush in RUN.
    drive(1, 0, 0, 0, 1, 32'h500, 1, 32'h600, 0, 0, 1); tick(); expect_core("seq.haltflush", 32'h304, 0, S_HALT);
    check("seq.haltinv", {31'd0, pc_invalid}, 32'd0);
    // Reset while asleep in WFI discards everything.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);       tick(); expect_core("seq.resume2", 32'h304, 1, S_RUN);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);       tick(); expect_core("seq.wfi3", 32'h304, 0, S_WFI);
    drive(0, 0, 0, 0, 1, 32'h900, 0, 0, 0, 1, 0); tick(); expect_core("seq.rstwfi", 32'h0, 0, S_IDLE);
    check("seq.rstcnt", fetch_cnt, 32'd0);
    // IDLE ignores everything but start_pc.
    drive(1, 0, 32'h700, 0, 1, 32'h900, 1, 32'hA00, 0, 0, 0); tick(); expect_core("seq.idle", 32'h0, 0, S_IDLE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
# pc_gen

Program-counter generator and fetch-enable sequencer: the stage directly upstream of the IF/ID register, driven by the pipeline controller's `stall`/`flush` outputs. Its `pc_invalid` output feeds the controller's misaligned-PC exception logic. It owns core start-up (idle until `start_pc`), sequential/branch/flush PC selection, and a wait-for-interrupt sleep state. It also keeps a fetch counter for core status reporting.

## Interface

Parameters:
- `RESET_PC`, 32'h0000_0000: PC value held while in reset and in IDLE.

Ports:
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-low (`rst`==0 resets on the next rising `clk`).
- `start_pc`  in  1  level/pulse; leaves IDLE.
- `start_addr`  in  32  first fetch address, sampled when leaving IDLE.
- `stall`  in  6  controller stall vector; only `stall[0]` (PC stage) used.
- `flush`  in  1  pipeline flush from controller.
- `flush_target`  in  32  redirect address accompanying `flush`.
- `branch_flag`  in  1  taken branch/jump resolved in ID.
- `branch_target`  in  32  branch destination.
- `is_wfi`  in  1  WFI decoded in ID.
- `wfi_wake`  in  1  interrupt pending / wake request.
- `halt_req`  in  1  debug halt request.
- `pc`  out  32  registered fetch address.
- `ce`  out  1  registered instruction-fetch enable.
- `pc_invalid`  out  1  `ce & (pc[1:0] != 2'b00)`, combinational.
- `pc_state`  out  2  IDLE=00, RUN=01, WFI=10, HALT=11 (registered).
- `fetch_cnt`  out  32  count of cycles in which a fetch was issued.

## Operation

- Reset (`rst`==0 at edge): `pc`=RESET_PC, `ce`=0, `pc_state`=IDLE, `fetch_cnt`=0; `pc_invalid`=0 as a consequence.
- IDLE: `ce`=0, `pc` held. `start_pc`=1 -> RUN, `pc`<=`start_addr`, `ce`<=1.
- RUN, next-PC priority (highest first):
  1. `halt_req` -> HALT, `ce`<=0, `pc` held.
  2. `flush` -> `pc`<=`flush_target` (overrides stall and branch).
  3. `stall[0]` -> `pc` held. `branch_flag`/`is_wfi` ignored; ID re-presents them.
  4. `is_wfi` -> WFI, `ce`<=0, `pc` held.
  5. `branch_flag` -> `pc`<=`branch_target`.
  6. otherwise `pc`<=`pc`+4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0).
- WFI: `ce`=0.
  - `flush` -> RUN at `flush_target`.
  - else `wfi_wake` -> RUN, `pc` unchanged, `ce`<=1.
  - else `halt_req` -> HALT.
  - If `flush` and `wfi_wake` coincide, `flush` wins.
- HALT: `ce`=0, `pc` held. `halt_req`=0 -> return to RUN with `ce`<=1 at the held `pc`. `flush` in HALT updates `pc`<=`flush_target` but stays HALT while `halt_req`=1.
- `fetch_cnt` increments by 1 each cycle with `ce`=1 and `stall[0]`=0. It wraps at 2^32 and resets only on `rst`.
- Misaligned targets are loaded as given; `pc_invalid` reports them and `pc` keeps advancing by 4 unless the controller stalls or flushes.

## Timing

- All outputs except `pc_invalid` are registered; one-cycle latency from any input to `pc`/`ce`/`pc_state`.
- `start_pc` at edge N -> `pc`=`start_addr`, `ce`=1 after edge N.
- `flush` at edge N -> `pc`=`flush_target` after edge N, regardless of `stall[0]`.
- Stall: `pc` constant for every cycle `stall[0]`=1; it advances on the first edge with `stall[0]`=0.
- `pc_invalid` is valid in the same cycle as `pc`, so the controller can react without an added cycle.
- Reset mid-operation, from any state: next edge forces all reset values. Pending branch/flush/WFI is discarded.

## Test plan

- Reset then `start_pc`=1 with `start_addr`=32'h0000_1000 -> `ce`=1, `pc` sequence 0x1000, 0x1004, 0x1008; `fetch_cnt`=3 after three fetch cycles.
- RUN at 0x2000; `stall[0]`=1 for 3 cycles with `branch_flag`=1 to 0x3000 -> `pc` stays 0x2000 and the branch is ignored. Then `stall[0]`=0 with `branch_flag`=1 -> `pc`=0x3000.
- `flush`=1, `flush_target`=0x8000, `stall[0]`=1 and `branch_flag`=1 in the same cycle -> `pc`=0x8000 next cycle.
- `is_wfi` at `pc`=0x100 -> WFI, `ce`=0 and `pc` stays 0x100 for 5 cycles. Then `wfi_wake` -> RUN, `ce`=1, `pc`=0x100, then 0x104.
- Branch to 0x0000_0006 -> `pc_invalid`=1 in the same cycle `pc`=0x6; `pc`=0xFFFF_FFFC with no stall -> next `pc`=0.
- `halt_req` in RUN, then `rst`=0 while in HALT -> `pc`=RESET_PC, `ce`=0, `pc_state`=00, `fetch_cnt`=0 after the edge.
